seq_mul: RTL and testbench

- Parametrised multi-cycle integer multiplier for the ALU datapath; next generation of the single-cycle signed 32-bit multiplier.
- Adds the following over the previous block:
  - configurable operand width;
  - configurable bits retired per cycle;
  - signed and unsigned modes;
  - the full double-width product;
  - valid/ready handshakes on input and output.
- Iterative shift-add on operand magnitudes, with sign correction on the final step.

---
 rtl/seq_mul.sv | 122 ++++++++++++
 tb/tb_seq_mul.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier on operand magnitudes, STEP multiplier bits per BUSY cycle.
// Result valid WIDTH/STEP edges after accept; held until out_ready, in_ready low outside IDLE.
module seq_mul #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int NSTEP = WIDTH / STEP;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    sh_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [CW-1:0]    counter;

    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    prod_fin;
    logic             accept;
    logic             last_step;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1])
            return ~v + WIDTH'(1);
        else
            return v;
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (state == BUSY) && (counter == CW'(1));

    // sh_a already carries the current bit offset, so each partial is a plain shift-and-select.
    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP; j++) begin
            if (mag_b[j])
                partial = partial + (sh_a << j);
        end
        acc_sum  = acc + partial;
        prod_fin = neg ? (~acc_sum + PW'(1)) : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            sh_a       <= '0;
            mag_b      <= '0;
            neg        <= 1'b0;
            counter    <= '0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            if (accept) begin
                sh_a    <= {{WIDTH{1'b0}}, magnitude(multiplicand, is_signed)};
                mag_b   <= magnitude(multiplier, is_signed);
                neg     <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                acc     <= '0;
                counter <= CW'(NSTEP);
            end else if (state == BUSY) begin
                acc     <= acc_sum;
                sh_a    <= sh_a << STEP;
                mag_b   <= mag_b >> STEP;
                counter <= counter - CW'(1);
                if (last_step)
                    {product_hi, product_lo} <= prod_fin;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: default, 8-bit/STEP=2 and 32-bit/STEP=4 instances against a product model.
module tb_seq_mul;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default instance
    logic        iv0 = 0, ir0, sg0 = 0, ov0, or0 = 0;
    logic [31:0] a0 = 0, b0 = 0, hi0, lo0;
    // WIDTH=8 STEP=2
    logic        iv1 = 0, ir1, sg1 = 0, ov1, or1 = 0;
    logic [7:0]  a1 = 0, b1 = 0, hi1, lo1;
    // WIDTH=32 STEP=4
    logic        iv2 = 0, ir2, sg2 = 0, ov2, or2 = 0;
    logic [31:0] a2 = 0, b2 = 0, hi2, lo2;

    logic [63:0] q0[$];
    logic [15:0] q1[$];
    logic [63:0] q2[$];

    seq_mul #(.WIDTH(32), .STEP(1)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .is_signed(sg0),
        .multiplicand(a0), .multiplier(b0), .out_valid(ov0), .out_ready(or0),
        .product_hi(hi0), .product_lo(lo0));

    seq_mul #(.WIDTH(8), .STEP(2)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .is_signed(sg1),
        .multiplicand(a1), .multiplier(b1), .out_valid(ov1), .out_ready(or1),
        .product_hi(hi1), .product_lo(lo1));

    seq_mul #(.WIDTH(32), .STEP(4)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .is_signed(sg2),
        .multiplicand(a2), .multiplier(b2), .out_valid(ov2), .out_ready(or2),
        .product_hi(hi2), .product_lo(lo2));

    function automatic logic [63:0] model64(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model16(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = sgn ? {{8{a[7]}}, a} : {8'b0, a};
        eb = sgn ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    // One operation on the default instance; optional output hold and input noise during BUSY.
    task automatic op0(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit toggle);
        int guard;
        int lat;
        logic [63:0] exp;
        logic [31:0] shi, slo;
        guard = 0;
        @(negedge clk);
        while (!ir0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ir0) begin
            checks++; errors++;
            $display("FAIL op0_accept: in_ready=%b required 1", ir0);
            return;
        end
        sg0 = sgn; a0 = a; b0 = b; iv0 = 1;
        q0.push_back(model64(sgn, a, b));
        @(negedge clk);
        iv0 = 0;
        lat = 0;
        while (!ov0 && lat < 200) begin
            if (toggle) begin
                a0  = $urandom;
                b0  = $urandom;
                sg0 = 1'($urandom_range(0, 1));
                iv0 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        iv0 = 0;
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL op0_latency: got %0d required 32", lat);
        end
        shi = hi0; slo = lo0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (hi0 !== shi || lo0 !== slo || ov0 !== 1'b1 || ir0 !== 1'b0) begin
                errors++;
                $display("FAIL op0_hold: hi=%h lo=%h ov=%b ir=%b required %h %h 1 0",
                         hi0, lo0, ov0, ir0, shi, slo);
            end
        end
        or0 = 1;
        exp = q0.pop_front();
        checks++;
        if ({hi0, lo0} !== exp) begin
            errors++;
            $display("FAIL op0_product: got %h required %h (a=%h b=%h s=%b)", {hi0, lo0}, exp, a, b, sgn);
        end
        @(negedge clk);
        or0 = 0;
        checks++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || {hi0, lo0} !== exp) begin
            errors++;
            $display("FAIL op0_release: ov=%b ir=%b prod=%h required 0 1 %h", ov0, ir0, {hi0, lo0}, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1; iv0 = 1; a0 = 32'h1234; b0 = 32'h5678; or0 = 1;
        repeat (3) @(negedge clk);
        rst = 0; iv0 = 0; or0 = 0;
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || hi0 !== 32'h0 || lo0 !== 32'h0) begin
            errors++;
            $display("FAIL reset: ir=%b ov=%b hi=%h lo=%h required 1 0 0 0", ir0, ov0, hi0, lo0);
        end
    endtask

    task automatic test_signed_unsigned();
        op0(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        op0(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        op0(1'b0, 32'h0, 32'hDEADBEEF, 0, 0);
    endtask

    task automatic test_corners();
        op0(1'b1, 32'h80000000, 32'h80000000, 0, 0);
        op0(1'b1, 32'h80000000, 32'h00000001, 0, 0);
        op0(1'b1, 32'd7, 32'hFFFFFFFD, 0, 0);
        op0(1'b0, 32'h80000000, 32'h80000000, 0, 0);
    endtask

    task automatic test_backpressure();
        op0(1'b1, 32'hC0FFEE11, 32'h0BADF00D, 10, 1);
        op0(1'b0, 32'h9ABCDEF0, 32'h13579BDF, 3, 1);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        sg0 = 0; a0 = 32'd1000; b0 = 32'd1000; iv0 = 1;
        @(negedge clk);
        iv0 = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || hi0 !== 32'h0 || lo0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: ir=%b ov=%b hi=%h lo=%h required 1 0 0 0", ir0, ov0, hi0, lo0);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_discard: out_valid cycles=%0d required 0", seen);
        end
        op0(1'b0, 32'd3, 32'd5, 0, 0);
    endtask

    task automatic test_sweep_w8();
        int lat;
        logic [7:0] a, b;
        logic sgn;
        logic [15:0] exp;
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 200; n++) begin
                sgn = (m == 1);
                a = 8'($urandom);
                b = 8'($urandom);
                if (n == 0) begin a = 8'h80; b = 8'h80; end
                if (n == 1) begin a = 8'hFF; b = 8'hFF; end
                @(negedge clk);
                sg1 = sgn; a1 = a; b1 = b; iv1 = 1;
                q1.push_back(model16(sgn, a, b));
                @(negedge clk);
                iv1 = 0;
                lat = 0;
                while (!ov1 && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                exp = q1.pop_front();
                checks++;
                if (lat !== 4 || {hi1, lo1} !== exp) begin
                    errors++;
                    $display("FAIL w8: a=%h b=%h s=%b got %h lat %0d required %h lat 4",
                             a, b, sgn, {hi1, lo1}, lat, exp);
                end
                or1 = 1;
                @(negedge clk);
                or1 = 0;
            end
        end
    endtask

    task automatic test_w32_s4();
        int lat;
        logic [31:0] a, b, slo;
        logic [63:0] exp;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            b = $urandom;
            slo = a * b;
            @(negedge clk);
            sg2 = 1; a2 = a; b2 = b; iv2 = 1;
            q2.push_back(model64(1'b1, a, b));
            @(negedge clk);
            iv2 = 0;
            lat = 0;
            while (!ov2 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            exp = q2.pop_front();
            checks++;
            if (lat !== 8 || lo2 !== slo || {hi2, lo2} !== exp) begin
                errors++;
                $display("FAIL w32s4: a=%h b=%h got %h lat %0d required %h lat 8",
                         a, b, {hi2, lo2}, lat, exp);
            end
            or2 = 1;
            @(negedge clk);
            or2 = 0;
        end
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_sweep_w8();
        test_w32_s4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
